// File: rtl/alu_sequencer.sv
// alu_sequencer
//   Multi-cycle instruction sequencer in front of an 8-bit ALU. It accepts one
//   16-bit instruction per valid/ready handshake. It reads a 4-entry register
//   file and drives the ALU operand/opcode registers. In the following cycle
//   it writes the ALU result back and updates the {C,V,Z,N} flags.
//
//   Instruction word:
//     [15:14] mode  00 reg-reg ALU, 01 reg-imm ALU, 10 LDI, 11 illegal
//     [13:11] op    ALU opcode (ADD/SUB/AND/OR/XOR, others illegal)
//     [10]    reserved, ignored
//     [9:8]   rd
//     [7:0]   imm   (reg-reg mode: rs = imm[1:0])
//
//   Handshake: a transfer happens on the rising edge where instr_valid and
//   instr_ready are both 1. instr_ready is 1 exactly in IDLE. The source must
//   hold instr stable until that edge. done pulses for one cycle at retirement,
//   and err qualifies it.
//
//   Ports
//     clk, rst                      clock, synchronous active-high reset
//     instr, instr_valid            instruction input and its valid
//     instr_ready                   sequencer is in IDLE
//     alu_operand_a/b, alu_op       registered ALU inputs
//     alu_result, alu_cout,
//     alu_overflow                  combinational ALU outputs
//     done, err                     retirement pulse and illegal-instruction flag
//     flags                         {C,V,Z,N}
//     dbg_sel, dbg_data             combinational register-file read port

module alu_sequencer #(
    parameter int DATA_W   = 8,
    parameter int NUM_REGS = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [15:0]       instr,
    input  logic              instr_valid,
    output logic              instr_ready,
    output logic [DATA_W-1:0] alu_operand_a,
    output logic [DATA_W-1:0] alu_operand_b,
    output logic [2:0]        alu_op,
    input  logic [DATA_W-1:0] alu_result,
    input  logic              alu_cout,
    input  logic              alu_overflow,
    output logic              done,
    output logic              err,
    output logic [3:0]        flags,
    input  logic [1:0]        dbg_sel,
    output logic [DATA_W-1:0] dbg_data
);

    // Opcode encodings shared with the ALU.
    localparam logic [2:0] OP_ADD = 3'd0;
    localparam logic [2:0] OP_SUB = 3'd1;
    localparam logic [2:0] OP_AND = 3'd2;
    localparam logic [2:0] OP_OR  = 3'd3;
    localparam logic [2:0] OP_XOR = 3'd4;

    localparam logic [1:0] MODE_RR  = 2'b00;
    localparam logic [1:0] MODE_LDI = 2'b10;
    localparam logic [1:0] MODE_ILL = 2'b11;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_EXEC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t            r_state;
    logic [DATA_W-1:0] r_regs [NUM_REGS];
    logic [DATA_W-1:0] r_a;
    logic [DATA_W-1:0] r_b;
    logic [2:0]        r_op;
    logic [1:0]        r_rd;
    logic [3:0]        r_flags;
    logic              r_done;
    logic              r_err;

    // Instruction field decode.
    logic [1:0]        w_mode;
    logic [2:0]        w_op;
    logic [1:0]        w_rd;
    logic [1:0]        w_rs;
    logic [DATA_W-1:0] w_imm;
    logic              w_op_legal;
    logic              w_unused_reserved;
    logic              w_is_arith;

    assign w_mode            = instr[15:14];
    assign w_op              = instr[13:11];
    assign w_rd              = instr[9:8];
    assign w_imm             = instr[7:0];
    assign w_rs              = instr[1:0];
    assign w_unused_reserved = instr[10];
    assign w_op_legal        = (w_op <= OP_XOR);

    // Only ADD/SUB produce meaningful carry and overflow. The logic ops clear C and V.
    assign w_is_arith = (r_op == OP_ADD) || (r_op == OP_SUB);

    assign instr_ready   = (r_state == S_IDLE);
    assign alu_operand_a = r_a;
    assign alu_operand_b = r_b;
    assign alu_op        = r_op;
    assign done          = r_done;
    assign err           = r_err;
    assign flags         = r_flags;
    assign dbg_data      = r_regs[dbg_sel];

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= S_IDLE;
            for (int i = 0; i < NUM_REGS; i++) begin
                r_regs[i] <= '0;
            end
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= '0;
            r_rd    <= '0;
            r_flags <= '0;
            r_done  <= 1'b0;
            r_err   <= 1'b0;
        end else begin
            // done/err are pulses that are only raised on the edge entering DONE.
            r_done <= 1'b0;
            r_err  <= 1'b0;
            unique case (r_state)
                S_IDLE: begin
                    if (instr_valid) begin
                        if (w_mode == MODE_LDI) begin
                            r_regs[w_rd] <= w_imm;
                            r_done       <= 1'b1;
                            r_state      <= S_DONE;
                        end else if ((w_mode == MODE_ILL) || !w_op_legal) begin
                            // Illegal: retire with err and leave all state untouched.
                            r_done  <= 1'b1;
                            r_err   <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            // Operands are captured now, so rd==rs reads the old value.
                            r_a     <= r_regs[w_rd];
                            r_b     <= (w_mode == MODE_RR) ? r_regs[w_rs] : w_imm;
                            r_op    <= w_op;
                            r_rd    <= w_rd;
                            r_state <= S_EXEC;
                        end
                    end
                end
                S_EXEC: begin
                    r_regs[r_rd] <= alu_result;
                    r_flags      <= {w_is_arith & alu_cout,
                                     w_is_arith & alu_overflow,
                                     (alu_result == '0),
                                     alu_result[DATA_W-1]};
                    r_done       <= 1'b1;
                    r_state      <= S_DONE;
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_sequencer.sv
// Testbench for alu_sequencer. It provides a behavioural 8-bit ALU and drives
// directed and random instructions. A reference model tracks the register file,
// flags and ALU input registers, and a queue holds the expected {err, latency}
// of each instruction.

module tb_alu_sequencer;

    localparam int W = 8;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] instr = '0;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [7:0]  alu_operand_a;
    logic [7:0]  alu_operand_b;
    logic [2:0]  alu_op;
    logic [7:0]  alu_result;
    logic        alu_cout;
    logic        alu_overflow;
    logic        done;
    logic        err;
    logic [3:0]  flags;
    logic [1:0]  dbg_sel = '0;
    logic [7:0]  dbg_data;

    int n_total = 0;
    int n_bad   = 0;

    // Each entry is {err, latency[6:0]}.
    logic [W-1:0] exp_q[$];

    int exp_regs[4];
    int exp_c, exp_v, exp_z, exp_n;
    int exp_a, exp_b, exp_op;

    alu_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .instr        (instr),
        .instr_valid  (instr_valid),
        .instr_ready  (instr_ready),
        .alu_operand_a(alu_operand_a),
        .alu_operand_b(alu_operand_b),
        .alu_op       (alu_op),
        .alu_result   (alu_result),
        .alu_cout     (alu_cout),
        .alu_overflow (alu_overflow),
        .done         (done),
        .err          (err),
        .flags        (flags),
        .dbg_sel      (dbg_sel),
        .dbg_data     (dbg_data)
    );

    // clock / reset
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: got=timeout want=finish");
        $fatal(1, "watchdog");
    end

    // Behavioural ALU: carry is the unsigned carry for ADD and the borrow for SUB.
    always_comb begin
        logic [8:0] ext;
        ext          = '0;
        alu_result   = '0;
        alu_cout     = 1'b0;
        alu_overflow = 1'b0;
        case (alu_op)
            3'd0: begin
                ext          = {1'b0, alu_operand_a} + {1'b0, alu_operand_b};
                alu_result   = ext[7:0];
                alu_cout     = ext[8];
                alu_overflow = (alu_operand_a[7] == alu_operand_b[7]) && (ext[7] != alu_operand_a[7]);
            end
            3'd1: begin
                ext          = {1'b0, alu_operand_a} - {1'b0, alu_operand_b};
                alu_result   = ext[7:0];
                alu_cout     = ext[8];
                alu_overflow = (alu_operand_a[7] != alu_operand_b[7]) && (ext[7] != alu_operand_a[7]);
            end
            3'd2: alu_result = alu_operand_a & alu_operand_b;
            3'd3: alu_result = alu_operand_a | alu_operand_b;
            3'd4: alu_result = alu_operand_a ^ alu_operand_b;
            default: begin
                alu_result   = 8'h5A;
                alu_cout     = 1'b1;
                alu_overflow = 1'b1;
            end
        endcase
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got=%0h want=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [15:0] mk(input int mode, input int op, input int rd, input int imm);
        return {2'(mode), 3'(op), 1'b0, 2'(rd), 8'(imm)};
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) exp_regs[i] = 0;
        exp_c = 0; exp_v = 0; exp_z = 0; exp_n = 0;
        exp_a = 0; exp_b = 0; exp_op = 0;
        exp_q.delete();
    endtask

    // Reference model computed with plain integer arithmetic.
    task automatic model(input logic [15:0] ins);
        int mode, op, rd, imm, rs, a, b, r, sa, sb, sr, lat;
        bit e;
        mode = int'(ins[15:14]);
        op   = int'(ins[13:11]);
        rd   = int'(ins[9:8]);
        imm  = int'(ins[7:0]);
        rs   = imm % 4;
        e    = 1'b0;
        lat  = 1;
        if (mode == 2) begin
            exp_regs[rd] = imm;
        end else if (mode == 3 || op > 4) begin
            e = 1'b1;
        end else begin
            a  = exp_regs[rd];
            b  = (mode == 0) ? exp_regs[rs] : imm;
            sa = (a > 127) ? a - 256 : a;
            sb = (b > 127) ? b - 256 : b;
            r  = 0;
            case (op)
                0: begin r = a + b; sr = sa + sb; exp_c = int'(r > 255); exp_v = int'(sr > 127 || sr < -128); end
                1: begin r = a - b; sr = sa - sb; exp_c = int'(a < b);   exp_v = int'(sr > 127 || sr < -128); end
                2: begin r = a & b; exp_c = 0; exp_v = 0; end
                3: begin r = a | b; exp_c = 0; exp_v = 0; end
                default: begin r = a ^ b; exp_c = 0; exp_v = 0; end
            endcase
            r = r & 255;
            exp_z = int'(r == 0);
            exp_n = int'(r > 127);
            exp_regs[rd] = r;
            exp_a = a; exp_b = b; exp_op = op;
            lat = 2;
        end
        exp_q.push_back({e, 7'(lat)});
    endtask

    // Called just after a falling edge; all reads finish before the next rising edge.
    task automatic check_state(input string tag);
        for (int i = 0; i < 4; i++) begin
            dbg_sel = 2'(i);
            #1;
            chk($sformatf("%s_r%0d", tag, i), 32'(dbg_data), 32'(exp_regs[i]));
        end
        chk({tag, "_flags"}, 32'(flags), {28'b0, exp_c[0], exp_v[0], exp_z[0], exp_n[0]});
        chk({tag, "_alu_a"}, 32'(alu_operand_a), 32'(exp_a));
        chk({tag, "_alu_b"}, 32'(alu_operand_b), 32'(exp_b));
        chk({tag, "_alu_op"}, 32'(alu_op), 32'(exp_op));
    endtask

    task automatic reset_dut();
        @(negedge clk);
        rst = 1'b1;
        instr_valid = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_ready", 32'(instr_ready), 32'd1);
        chk("rst_done", 32'(done), 32'd0);
        chk("rst_err", 32'(err), 32'd0);
        check_state("rst");
    endtask

    // Driver: issue one instruction, measure latency, check err and state.
    task automatic send(input logic [15:0] ins);
        int guard, lat;
        logic [W-1:0] e;
        model(ins);
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        guard = 0;
        while (!instr_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        if (!instr_ready) begin
            chk("accept_timeout", 32'd0, 32'd1);
            instr_valid = 1'b0;
            void'(exp_q.pop_back());
            return;
        end
        @(posedge clk);
        #1 instr_valid = 1'b0;
        lat = 0;
        do begin
            @(negedge clk);
            lat++;
        end while (!done && lat < 8);
        e = exp_q.pop_front();
        if (!done) chk("done_timeout", 32'd0, 32'd1);
        chk("latency", 32'(lat), 32'(e[6:0]));
        chk("err", 32'(err), 32'(e[7]));
        chk("ready_in_done", 32'(instr_ready), 32'd0);
        @(negedge clk);
        chk("done_pulse", 32'(done), 32'd0);
        chk("ready_after", 32'(instr_ready), 32'd1);
        check_state($sformatf("ins%04h", ins));
    endtask

    initial begin
        logic [15:0] ins;
        logic [W-1:0] e;
        int mode_pick;

        reset_dut();

        // ADD with signed overflow: 0x7F + 0x01
        send(mk(2, 0, 1, 8'h7F));
        send(mk(2, 0, 2, 8'h01));
        send(mk(0, 0, 1, 2));
        chk("add_ovf_flags", 32'(flags), 32'b0101);

        // SUB reg-imm to zero
        send(mk(2, 0, 0, 8'h05));
        send(mk(1, 1, 0, 8'h05));
        chk("sub_zero_flags", 32'(flags), 32'b0010);

        // Set C via 0xFF + 1, then XOR must clear C
        send(mk(2, 0, 2, 8'hFF));
        send(mk(1, 0, 2, 8'h01));
        chk("carry_flags", 32'(flags), 32'b1010);
        send(mk(2, 0, 1, 8'hF0));
        send(mk(1, 4, 1, 8'h0F));
        chk("xor_flags", 32'(flags), 32'b0001);

        // Illegal instructions
        send(16'hC000);
        send(mk(0, 5, 1, 0));
        send(mk(1, 7, 2, 3));

        // rd == rs
        send(mk(2, 0, 3, 8'h81));
        send(mk(0, 0, 3, 3));

        // Back-to-back ADDs with instr_valid held high
        ins = mk(1, 0, 3, 1);
        @(negedge clk);
        instr = ins;
        instr_valid = 1'b1;
        for (int i = 0; i < 9; i++) begin
            if (i > 0) @(negedge clk);
            chk($sformatf("hold_ready%0d", i), 32'(instr_ready), 32'(i % 3 == 0));
            chk($sformatf("hold_done%0d", i), 32'(done), 32'(i % 3 == 2));
            if (instr_ready && instr_valid) model(ins);
            if (done && exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("hold_err", 32'(err), 32'(e[7]));
            end
            if (i == 7) instr_valid = 1'b0;
        end
        @(negedge clk);
        check_state("hold");

        // Random instructions
        for (int n = 0; n < 60; n++) begin
            mode_pick = $urandom_range(0, 9);
            ins = {16'($urandom_range(0, 65535))};
            if (mode_pick <= 3)      ins[15:14] = 2'b00;
            else if (mode_pick <= 6) ins[15:14] = 2'b01;
            else if (mode_pick <= 8) ins[15:14] = 2'b10;
            else                     ins[15:14] = 2'b11;
            if ($urandom_range(0, 3) != 0) ins[13:11] = 3'($urandom_range(0, 4));
            send(ins);
        end

        // Reset during EXEC of ADD r3 aborts it
        send(mk(2, 0, 3, 8'h80));
        send(mk(0, 0, 3, 3));
        @(negedge clk);
        instr = mk(1, 0, 3, 8'h11);
        instr_valid = 1'b1;
        @(posedge clk);
        #1 instr_valid = 1'b0;
        @(negedge clk);
        chk("exec_ready", 32'(instr_ready), 32'd0);
        rst = 1'b1;
        @(negedge clk);
        chk("rst_mid_done", 32'(done), 32'd0);
        rst = 1'b0;
        model_reset();
        @(negedge clk);
        chk("rst_mid_done2", 32'(done), 32'd0);
        chk("rst_mid_ready", 32'(instr_ready), 32'd1);
        check_state("rst_mid");

        $display("test done: total=%0d bad=%0d", n_total, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_sequencer.md
Name: alu_sequencer

Overview:
- Multi-cycle instruction sequencer that drives the 8-bit ALU's operand/opcode inputs and consumes its result, carry and overflow outputs.
- Accepts one 16-bit instruction per transaction over a valid/ready handshake. Reads a 4-entry 8-bit register file, issues the ALU operation, then writes the result back.
- Maintains C/V/Z/N flags and signals completion.
- Sits between the instruction source (test bench or future fetch unit) and the ALU instance.

Parameters:
- DATA_W, 8, datapath width; fixed at 8 to match the ALU.
- NUM_REGS, 4, register-file depth; fixed at 4 (2-bit register fields).

Ports:
- clk  input  1  clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- instr  input  16  instruction word, sampled on accept.
- instr_valid  input  1  instr is valid.
- instr_ready  output  1  sequencer can accept; equals (state==IDLE).
- alu_operand_a  output  8  registered ALU operand A (signed).
- alu_operand_b  output  8  registered ALU operand B (signed).
- alu_op  output  3  registered ALU opcode, using the `ADD/`SUB/`AND/`OR/`XOR encodings from header/opcodes.vh.
- alu_result  input  8  ALU result, combinational from the alu_* outputs.
- alu_cout  input  1  ALU carry/borrow out.
- alu_overflow  input  1  ALU signed overflow.
- done  output  1  one-cycle pulse when an instruction retires.
- err  output  1  valid with done; 1 = illegal instruction, nothing written.
- flags  output  4  {C,V,Z,N}, registered.
- dbg_sel  input  2  register-file read select.
- dbg_data  output  8  combinational read of reg[dbg_sel].

Behaviour:
- Instruction format:
  - [15:14] mode: 00 reg-reg ALU, 01 reg-imm ALU, 10 load-immediate (LDI), 11 illegal.
  - [13:11] op.
  - [10] reserved, ignored.
  - [9:8] rd.
  - [7:0] imm; in reg-reg mode rs = imm[1:0].
- Reset:
  - state=IDLE, so instr_ready=1 from the first post-reset cycle.
  - reg[0..3]=0, flags=0, done=0, err=0, alu_operand_a=0, alu_operand_b=0, alu_op=0.
  - Reset mid-instruction aborts it: no writeback, no done.
- FSM has three states: IDLE, EXEC, DONE.
- IDLE:
  - Accept occurs on the edge where instr_valid & instr_ready; instr is sampled at that edge.
  - ALU mode with op in {ADD,SUB,AND,OR,XOR}: latch alu_operand_a=reg[rd]; alu_operand_b = reg[rs] (mode 00) or imm (mode 01); alu_op=op. Go to EXEC.
  - LDI: reg[rd]<=imm at the accept edge; flags unchanged. Go to DONE, err=0.
  - Mode 11, or an ALU op not among the five: go to DONE with err=1. No register or flag change; alu_* outputs hold.
  - instr_valid while not ready is ignored. The source must hold instr stable until accepted.
- EXEC:
  - ALU outputs settle combinationally during this cycle.
  - At the exit edge: reg[rd]<=alu_result; Z=(alu_result==0); N=alu_result[7].
  - ADD/SUB: C=alu_cout, V=alu_overflow.
  - AND/OR/XOR: C=0, V=0; alu_cout and alu_overflow are ignored for these ops.
  - Go to DONE.
- DONE:
  - done=1 for exactly this cycle; err is valid in this cycle and 0 otherwise.
  - instr_ready=0. Next state is IDLE.
- Latency from the accept edge:
  - ALU ops: done in the 2nd cycle after accept.
  - LDI and illegal: done in the 1st cycle after accept.
  - Maximum throughput: one ALU instruction per 3 cycles; one LDI per 2 cycles.
- Hazards:
  - rd==rs is legal. Operands are read at accept, before writeback.
  - Back-to-back dependent instructions see the prior writeback because accept happens only in IDLE.
- alu_operand_a, alu_operand_b and alu_op hold their last values outside EXEC.
- dbg_data reflects writes from the edge after the write.

Test Plan:
- Reset then LDI r1=0x7F, LDI r2=0x01, ADD reg-reg rd=r1 rs=r2 -> r1=0x80, flags C=0 V=1 Z=0 N=1, done 2 cycles after ADD accept, err=0.
- LDI r0=0x05; SUB reg-imm rd=r0 imm=0x05 -> r0=0x00, Z=1, N=0, V=0; C equals alu_cout as driven by the ALU.
- Preset C=1 via ADD 0xFF+0x01 (r=0x00, C=1, Z=1); then XOR reg-imm 0xF0^0x0F -> r=0xFF, C=0, V=0, N=1, Z=0.
- Instruction 0xC000 (mode 11) and an ALU op with an undefined opcode -> done with err=1 one cycle after accept; registers and flags unchanged.
- Hold instr_valid=1 continuously with 3 ADDs -> exactly one accept per 3 cycles; instr_ready low in EXEC and DONE.
- Assert rst during EXEC of ADD r3 -> no done; r3=0; flags=0; instr_ready=1 on the cycle after rst deasserts.
